// File: rtl/key_event_sched.sv
// key_event_sched: latches one pending event per key and serialises them round-robin onto a
// valid/ready stream. Auto-repeat for held keys is compiled in with `define KEY_AUTOREPEAT_EN.
module key_event_sched #(
  parameter int N_KEYS     = 4,
  parameter int IDX_W      = 2,
  parameter int PRESC_BITS = 17,
  parameter int REP_W      = 4,
  parameter int REP_DELAY  = 8,
  parameter int REP_PERIOD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] press,
  input  logic [N_KEYS-1:0] level,
  output logic              ev_valid,
  output logic [IDX_W-1:0]  ev_key,
  output logic              ev_repeat,
  input  logic              ev_ready,
  output logic              drop
);

  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [N_KEYS-1:0] fire, set_ev, gnt_vec;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              ev_valid_q, ev_valid_d;
  logic [IDX_W-1:0]  ev_key_q, ev_key_d;
  logic              drop_q, drop_d;
  logic              load, grant_found;
  logic [IDX_W-1:0]  grant_idx;

  assign load   = !ev_valid_q || ev_ready;
  assign set_ev = press | fire;

  // First pass covers ptr..N-1; the second pass then yields the lowest index below ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!grant_found && pending_q[i] && (IDX_W'(i) >= ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_KEYS; i++) begin
      if (!grant_found && pending_q[i]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      gnt_vec[i] = load && grant_found && (grant_idx == IDX_W'(i));
    end
  end

  // A set event on the key being granted keeps it pending and does not count as a coalesce.
  always_comb begin
    pending_d  = (pending_q & ~gnt_vec) | set_ev;
    drop_d     = |(set_ev & pending_q & ~gnt_vec);
    ev_valid_d = ev_valid_q;
    ev_key_d   = ev_key_q;
    ptr_d      = ptr_q;
    if (load) begin
      ev_valid_d = grant_found;
      if (grant_found) begin
        ev_key_d = grant_idx;
        ptr_d    = (grant_idx == IDX_W'(N_KEYS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      ev_valid_q <= ev_valid_d;
      ev_key_q   <= ev_key_d;
      drop_q     <= drop_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_key   = ev_key_q;
  assign drop     = drop_q;

`ifdef KEY_AUTOREPEAT_EN
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [N_KEYS-1:0]     pend_rep_q, pend_rep_d;
  logic                  ev_repeat_q, ev_repeat_d;
  logic                  tick;

  assign presc_d = presc_q + 1'b1;
  assign tick    = &presc_q;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_rep
    logic [REP_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (press[gi]) begin
        cnt_d = REP_W'(REP_DELAY);
      end else if (!level[gi]) begin
        cnt_d = '0;
      end else if (tick && (cnt_q != '0)) begin
        cnt_d = (cnt_q == REP_W'(1)) ? REP_W'(REP_PERIOD) : cnt_q - 1'b1;
      end
    end

    assign fire[gi] = tick && level[gi] && !press[gi] && (cnt_q == REP_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

  // A repeat coalescing into a still-pending press must not turn it into a repeat.
  always_comb begin
    pend_rep_d = pend_rep_q;
    for (int i = 0; i < N_KEYS; i++) begin
      if (press[i]) begin
        pend_rep_d[i] = 1'b0;
      end else if (fire[i] && !(pending_q[i] && !gnt_vec[i])) begin
        pend_rep_d[i] = 1'b1;
      end
    end
    ev_repeat_d = ev_repeat_q;
    if (load && grant_found) ev_repeat_d = pend_rep_q[grant_idx];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      pend_rep_q  <= '0;
      ev_repeat_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pend_rep_q  <= pend_rep_d;
      ev_repeat_q <= ev_repeat_d;
    end
  end

  assign ev_repeat = ev_repeat_q;
`else
  logic                                                 unused_level;
  logic [PRESC_BITS+REP_W+REP_DELAY+REP_PERIOD-1:0]     unused_cfg;

  assign unused_level = ^level;
  assign unused_cfg   = '0;
  assign fire         = '0;
  assign ev_repeat    = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_sched.sv
// Directed bench for key_event_sched: handshake, round-robin order, coalescing, reset, auto-repeat.
module tb_key_event_sched;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] press = '0;
  logic [3:0] level = '0;
  logic       ev_valid;
  logic [1:0] ev_key;
  logic       ev_repeat;
  logic       ev_ready = 1'b0;
  logic       drop;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int log_key[$];
  int log_rep[$];
  int log_cyc[$];

  key_event_sched #(
    .N_KEYS(4), .IDX_W(2), .PRESC_BITS(2), .REP_W(4), .REP_DELAY(2), .REP_PERIOD(1)
  ) dut (
    .CLK(CLK), .RST(RST), .press(press), .level(level),
    .ev_valid(ev_valid), .ev_key(ev_key), .ev_repeat(ev_repeat),
    .ev_ready(ev_ready), .drop(drop)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Records any handshake completing at the coming edge, then advances one cycle.
  task automatic step();
    if (!RST && ev_valid && ev_ready) begin
      log_key.push_back(int'(ev_key));
      log_rep.push_back(int'(ev_repeat));
      log_cyc.push_back(cyc);
      $display("[TB] cycle %0d: event key=%0d repeat=%0d", cyc, ev_key, ev_repeat);
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (drop) drop_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    press = '0;
    level = '0;
    ev_ready = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc = 0;
    drop_cnt = 0;
    log_key.delete();
    log_rep.delete();
    log_cyc.delete();
  endtask

  int n0;

  initial begin
    // Reset state
    do_reset();
    check("reset_valid", ev_valid, 0);
    check("reset_key", ev_key, 0);
    check("reset_repeat", ev_repeat, 0);
    check("reset_drop", drop, 0);

    // Single press with consumer ready: valid for exactly one cycle, two cycles after press
    ev_ready = 1'b1;
    press = 4'b0100; step(); press = '0;
    check("single_t1_valid", ev_valid, 0);
    step();
    check("single_t2_valid", ev_valid, 1);
    check("single_t2_key", ev_key, 2);
    check("single_t2_repeat", ev_repeat, 0);
    step();
    check("single_t3_valid", ev_valid, 0);
    check("single_count", log_key.size(), 1);
    check("single_drop", drop_cnt, 0);

    // Three keys at once with back-pressure, plus a re-press of the buffered key
    do_reset();
    press = 4'b1011; step(); press = '0;
    step();
    check("rr_buf_valid", ev_valid, 1);
    check("rr_buf_key", ev_key, 0);
    steps(3);
    check("rr_hold_key", ev_key, 0);
    press = 4'b0001; step(); press = '0;
    steps(2);
    check("rr_hold2_valid", ev_valid, 1);
    check("rr_hold2_key", ev_key, 0);
    ev_ready = 1'b1;
    steps(6);
    check("rr_count", log_key.size(), 4);
    if (log_key.size() == 4) begin
      check("rr_key0", log_key[0], 0);
      check("rr_key1", log_key[1], 1);
      check("rr_key2", log_key[2], 3);
      check("rr_key3", log_key[3], 0);
      check("rr_b2b_1", log_cyc[1] - log_cyc[0], 1);
      check("rr_b2b_2", log_cyc[2] - log_cyc[1], 1);
      check("rr_b2b_3", log_cyc[3] - log_cyc[2], 1);
      check("rr_rep3", log_rep[3], 0);
    end
    check("rr_drop", drop_cnt, 0);
    check("rr_idle_valid", ev_valid, 0);

    // Coalescing: second press on a still-pending key gives one drop and one event
    do_reset();
    press = 4'b0001; step(); press = '0;
    step();
    press = 4'b0010; step(); press = '0;
    steps(4);
    check("coal_no_drop_yet", drop_cnt, 0);
    press = 4'b0010; step(); press = '0;
    check("coal_drop_pulse", drop, 1);
    step();
    check("coal_drop_cleared", drop, 0);
    ev_ready = 1'b1;
    steps(4);
    check("coal_drop_count", drop_cnt, 1);
    check("coal_count", log_key.size(), 2);
    if (log_key.size() == 2) begin
      check("coal_key0", log_key[0], 0);
      check("coal_key1", log_key[1], 1);
    end

    // Set event coinciding with a grant on the same key: stays pending, no drop
    do_reset();
    ev_ready = 1'b1;
    press = 4'b0100; step();
    press = 4'b0100; step(); press = '0;
    steps(4);
    check("sg_count", log_key.size(), 2);
    if (log_key.size() == 2) begin
      check("sg_key0", log_key[0], 2);
      check("sg_key1", log_key[1], 2);
    end
    check("sg_drop", drop_cnt, 0);

    // Asynchronous reset while an event is buffered and two keys are pending
    do_reset();
    press = 4'b0111; step(); press = '0;
    step();
    check("rst_pre_valid", ev_valid, 1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_valid", ev_valid, 0);
    check("rst_async_key", ev_key, 0);
    check("rst_async_repeat", ev_repeat, 0);
    check("rst_async_drop", drop, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ev_ready = 1'b1;
    log_key.delete();
    steps(6);
    check("rst_no_stale", log_key.size(), 0);
    check("rst_idle_valid", ev_valid, 0);

`ifdef KEY_AUTOREPEAT_EN
    // Held key: press event, then repeats 5..8 cycles later and every 4 cycles after that
    do_reset();
    ev_ready = 1'b1;
    level = 4'b1000;
    press = 4'b1000; step(); press = '0;
    steps(24);
    check("ar_enough_events", log_key.size() >= 4, 1);
    if (log_key.size() >= 4) begin
      check("ar_press_key", log_key[0], 3);
      check("ar_press_rep", log_rep[0], 0);
      check("ar_first_gap_ok",
            (log_cyc[1] - log_cyc[0] >= 5) && (log_cyc[1] - log_cyc[0] <= 8), 1);
      for (int i = 1; i < log_key.size(); i++) begin
        check("ar_rep_key", log_key[i], 3);
        check("ar_rep_flag", log_rep[i], 1);
        if (i >= 2) check("ar_period", log_cyc[i] - log_cyc[i-1], 4);
      end
    end
    n0 = log_key.size();
    level = '0;
    steps(12);
    check("ar_stop_after_release", (log_key.size() - n0) <= 1, 1);
    check("ar_drop", drop_cnt, 0);
`else
    // Levels held high without auto-repeat: only the four presses produce events
    do_reset();
    ev_ready = 1'b1;
    level = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      press = 4'b0001 << k;
      step();
    end
    press = '0;
    steps(30);
    check("norep_count", log_key.size(), 4);
    if (log_key.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("norep_key", log_key[k], k);
        check("norep_rep", log_rep[k], 0);
      end
    end
    check("norep_drop", drop_cnt, 0);
    level = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
